// File: rtl/rx32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// FSM state encoding and the legality check for a request.
package rx32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  // Unsigned widths exist only for loads; stores accept B/H/W.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: is_legal = 1'b1;
      F3_BU, F3_HU:     is_legal = !we;
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a byte/halfword for loads,
// and merges store data into the old word for sub-word stores.
module lsu_lane_align
  import rx32_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = old_word;
    endcase

    // Untouched lanes keep the word just read from memory.
    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8] = new_data[7:0];
      F3_H:    store_word[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory; sub-word stores
// use read-modify-write. Define LSU_ALIGN_CHECK_EN to reject misaligned accesses.
module load_store_unit
  import rx32_lsu_pkg::*;
#(
  parameter int ADDR_W              = 32,
  parameter bit RESP_ERR_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              resp_misaligned,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state, state_next;
  logic              we_q, err_q, mis_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_q;

  logic        accept, legal, bad_f3, mis_in;
  logic [2:0]  f3_eff;
  logic [31:0] load_data, store_word;

  assign accept = req_valid && (state == IDLE);
  assign legal  = is_legal(req_we, req_funct3);
  assign bad_f3 = !legal && RESP_ERR_ON_ILLEGAL;
  // Illegal codes that are not reported fall back to a full word access.
  assign f3_eff = legal ? req_funct3 : F3_W;

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    case (f3_eff)
      F3_H, F3_HU: mis_in = req_addr[0];
      F3_W:        mis_in = |req_addr[1:0];
      default:     mis_in = 1'b0;
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .old_word   (mem_rdata),
    .new_data   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // data_q holds the SW data from accept, or the loaded/merged word after READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= bad_f3;
      mis_q   <= mis_in;
      f3_q    <= f3_eff;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      data_q  <= req_wdata;
    end else if (state == READ) begin
      data_q  <= we_q ? store_word : load_data;
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_err        = 1'b0;
    resp_misaligned = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_f3 || mis_in)           state_next = RESP;
          else if (req_we && f3_eff == F3_W) state_next = WRITE;
          else                            state_next = READ;
        end
      end
      READ: begin
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        state_next = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata  = data_q;
        state_next = RESP;
      end
      RESP: begin
        resp_valid      = 1'b1;
        resp_err        = err_q;
        resp_misaligned = mis_q;
        if (!we_q && !err_q && !mis_q) resp_rdata = data_q;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses and memory writes; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          cyc;
    string       name;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  load_store_unit #(.ADDR_W(32), .RESP_ERR_ON_ILLEGAL(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .resp_misaligned (resp_misaligned),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every response and every memory write must match a queued expectation.
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (!reset) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp actual=resp_valid required=idle");
        end else begin
          e = resp_q.pop_front();
          check_output({e.name, "_rdata"}, resp_rdata, e.rdata);
          check_output({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check_output({e.name, "_mis"}, {31'b0, resp_misaligned}, {31'b0, e.mis});
          check_output({e.name, "_cycle"}, cyc, e.cyc);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_write actual=addr 0x%08h data 0x%08h required=no write", mem_addr, mem_wdata);
        end else begin
          w = wr_q.pop_front();
          check_output("write_addr", mem_addr, w.addr);
          check_output("write_data", mem_wdata, w.data);
          check_output("write_cycle", cyc, w.cyc);
        end
      end
    end
  end

  // Issues one request (holding req_valid until accepted) and queues its expectations.
  task automatic apply_stimulus(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input logic exp_mis,
                                input int lat, input logic has_wr, input int wr_off,
                                input logic [31:0] wr_data);
    int    guard;
    resp_t e;
    wr_t   w;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_accept actual=req_ready low for 20 cycles required=accept", name);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.mis   = exp_mis;
    e.cyc   = cyc + lat - 1;
    e.name  = name;
    resp_q.push_back(e);
    if (has_wr) begin
      w.addr = {addr[31:2], 2'b00};
      w.data = wr_data;
      w.cyc  = cyc + wr_off;
      wr_q.push_back(w);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check_output({name, "_pending"}, resp_q.size() + wr_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    check_output("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_output("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;

    //              name    we    f3      addr          wdata         rdata         err   mis   lat wr    off wdata
    apply_stimulus("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("lbu11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("lh12",  1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("sb13",  1'b1, 3'b000, 32'h13, 32'h00000055, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1, 32'h5599AABB);
    apply_stimulus("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'h5599AABB, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("sh10",  1'b1, 3'b001, 32'h10, 32'hABCD1234, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1, 32'h55991234);
    apply_stimulus("lhu10", 1'b0, 3'b101, 32'h10, 32'h0,        32'h00001234, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("lhu12", 1'b0, 3'b101, 32'h12, 32'h0,        32'h00005599, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'h00000055, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("sw20",  1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2, 1'b1, 0, 32'hDEADBEEF);
    apply_stimulus("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    apply_stimulus("lw22",  1'b0, 3'b010, 32'h22, 32'h0,        32'h0,        1'b0, 1'b1, 1, 1'b0, 0, 32'h0);
    apply_stimulus("lh13",  1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        1'b0, 1'b1, 1, 1'b0, 0, 32'h0);
`else
    apply_stimulus("lw22",  1'b0, 3'b010, 32'h22, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    apply_stimulus("lh13",  1'b0, 3'b001, 32'h13, 32'h0,        32'h00005599, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
`endif
    apply_stimulus("ld011", 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1'b0, 1, 1'b0, 0, 32'h0);
    apply_stimulus("st100", 1'b1, 3'b100, 32'h20, 32'h12345678, 32'h0,        1'b1, 1'b0, 1, 1'b0, 0, 32'h0);
    apply_stimulus("lw20b", 1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    drain("main");

    // Abort an SH while it sits in READ; nothing may be written afterwards.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h16;
    req_wdata  = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_output("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("abort_mem_we", {31'b0, mem_we}, 32'd0);
    check_output("abort_mem_addr", mem_addr, 32'h0);
    check_output("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check_output("abort_mem_word", mem[5], 32'h11223344);
    apply_stimulus("lw14",  1'b0, 3'b010, 32'h14, 32'h0,        32'h11223344, 1'b0, 1'b0, 2, 1'b0, 0, 32'h0);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-addressed data memory (single 32-bit word port, combinational read, synchronous write).
- Accepts one RV32I load/store per handshake and supports byte and halfword accesses:
  - loads: word read, then lane extract and sign/zero extend;
  - sub-word stores: read-modify-write, because the memory only writes whole words.
- Returns one response per request.

Parameters:
- ADDR_W, 32, width of the request address and of mem_addr.
- RESP_ERR_ON_ILLEGAL, 1, when 1 an illegal funct3 raises resp_err; when 0 it is treated as LW/SW.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  illegal funct3, valid with resp_valid
- resp_misaligned  out  1  misaligned access, valid with resp_valid
- mem_we  out  1  word write enable to data memory
- mem_addr  out  ADDR_W  byte address to memory, bits [1:0] always 0
- mem_wdata  out  32  word write data
- mem_rdata  in  32  combinational word read data

Behaviour:
- Reset (asynchronous) forces:
  - state = IDLE;
  - req_ready = 1;
  - resp_valid, resp_err, resp_misaligned, mem_we = 0;
  - resp_rdata, mem_addr, mem_wdata = 0.
- If reset asserts mid-operation, the operation is abandoned. No write is issued after reset deasserts.
- funct3 encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Alignment rules:
  - halfword requires addr[0] = 0;
  - word requires addr[1:0] = 0.
- States: IDLE, READ, WRITE, RESP. req_ready = 1 only in IDLE. A request is accepted on req_valid & req_ready, and it latches we, funct3, addr and wdata.
- IDLE transitions on accept:
  - illegal or misaligned -> RESP (no memory write);
  - load -> READ;
  - SW -> WRITE;
  - SB/SH -> READ.
- READ:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}; mem_rdata is captured at the end of the cycle.
  - load -> RESP with extended data registered.
  - SB/SH -> WRITE with merged word registered.
- Lane extraction for loads:
  - byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Merge for sub-word stores: replace the addressed byte or halfword lane of the captured word with req_wdata[7:0] or [15:0]; all other lanes are preserved.
- WRITE: mem_we = 1 for exactly one cycle, with mem_wdata = merged word (SW: req_wdata). Next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- mem_we = 0 in every state except WRITE.
- Latency from accept to resp_valid:
  - misaligned/illegal: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- Back-to-back: after a response, the next request can be accepted the following cycle. req_valid held during a busy state waits and is not dropped.

Optional Feature:
- LSU_ALIGN_CHECK_EN defined:
  - misaligned accesses are not performed and respond with resp_misaligned = 1;
  - resp_rdata = 0, and memory is untouched.
- Not defined:
  - resp_misaligned is tied to 0;
  - halfword uses addr[0] = 0 and word uses addr[1:0] = 0 (low bits ignored), and the access proceeds normally.

Decomposition:
- Package rx32_lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, READ, WRITE, RESP};
  - function is_legal(we, funct3).
- Sub-module lsu_lane_align (combinational): extract/extend for loads and merge for stores, driven by funct3, addr[1:0], old word and new data.

Test Plan:
- Memory word 0x10 = 0x8899AABB; LB at 0x11 -> resp_rdata = 0xFFFFFFAA two cycles after accept. LBU at 0x11 -> 0x000000AA. LH at 0x12 -> 0xFFFF8899.
- SB of 0x55 at 0x13 on word 0x8899AABB -> READ then WRITE, with mem_we for exactly 1 cycle and mem_wdata = 0x5599AABB. resp_valid comes 3 cycles after accept.
- SW of 0xDEADBEEF at 0x20 -> mem_we high in the cycle after accept, mem_addr = 0x20, no READ state. A following LW at 0x20 returns 0xDEADBEEF.
- With LSU_ALIGN_CHECK_EN, LW at 0x22 -> resp_misaligned = 1 next cycle and mem_we never asserted. Without the macro, the same access reads word 0x20.
- req_we = 0, funct3 = 011 -> resp_err = 1, no memory access. Store with funct3 = 100 -> resp_err = 1, mem_we stays 0.
- Reset asserted during the READ of an SH -> outputs return to reset values immediately, mem_we stays 0 after release, and req_ready = 1 in the first cycle after reset.
